// File: rtl/led_breath_pwm.sv
// LED breathing/blinking PWM driver: PWM counter, step prescaler, up/down ramp, registered output.
// Build option LED_BREATH_GAMMA_EN selects quadratic duty correction; level always reports the linear value.
module led_breath_pwm #(
   parameter int PWM_BITS     = 8,
   parameter int STEP_PERIODS = 184
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                mode,
   output logic                led,
   output logic [PWM_BITS-1:0] level,
   output logic                period_tick
);

   localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] ONE       = PWM_BITS'(1);
   localparam logic [15:0]         STEP_LAST = 16'(STEP_PERIODS - 1);

   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [15:0]         step_cnt_q, step_cnt_d;
   logic [PWM_BITS-1:0] level_q, level_d;
   logic                dir_up_q, dir_up_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic                led_q, led_d;
   logic                tick_q, tick_d;
   logic                wrap, step, dir_eff;
   logic [PWM_BITS-1:0] duty_next;

`ifdef LED_BREATH_GAMMA_EN
   logic [2*PWM_BITS-1:0] level_sq;
   assign level_sq  = (2*PWM_BITS)'(level_d) * (2*PWM_BITS)'(level_d);
   assign duty_next = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
   assign duty_next = level_d;
`endif

   always_comb begin
      pwm_cnt_d  = pwm_cnt_q;
      step_cnt_d = step_cnt_q;
      level_d    = level_q;
      dir_up_d   = dir_up_q;
      led_d      = 1'b0;
      tick_d     = 1'b0;
      dir_eff    = dir_up_q;
      wrap       = (pwm_cnt_q == MAX);
      step       = wrap && (step_cnt_q == STEP_LAST);
      if (en) begin
         led_d     = (pwm_cnt_q < duty_q);
         pwm_cnt_d = pwm_cnt_q + ONE;
         if (wrap) begin
            step_cnt_d = step ? '0 : step_cnt_q + 16'd1;
         end
         if (step) begin
            if (mode) begin
               level_d = (level_q != '0) ? '0 : MAX;
            end else begin
               // At the extremes the direction is implied by the level, which also
               // re-establishes a sane direction after leaving blink mode.
               if (level_q == MAX) begin
                  dir_eff = 1'b0;
               end else if (level_q == '0) begin
                  dir_eff = 1'b1;
               end
               dir_up_d = dir_eff;
               level_d  = dir_eff ? level_q + ONE : level_q - ONE;
            end
            tick_d = (level_d == '0);
         end
      end
   end

   // Duty only reloads at the period boundary so a period is never cut short.
   always_comb begin
      duty_d = duty_q;
      if (en && wrap) begin
         duty_d = duty_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt_q  <= '0;
         step_cnt_q <= '0;
         level_q    <= '0;
         dir_up_q   <= 1'b1;
         duty_q     <= '0;
         led_q      <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         pwm_cnt_q  <= pwm_cnt_d;
         step_cnt_q <= step_cnt_d;
         level_q    <= level_d;
         dir_up_q   <= dir_up_d;
         duty_q     <= duty_d;
         led_q      <= led_d;
         tick_q     <= tick_d;
      end
   end

   assign led         = led_q;
   assign level       = level_q;
   assign period_tick = tick_q;

endmodule

// File: tb/tb_led_breath_pwm.sv
// Bench for led_breath_pwm (PWM_BITS=4, STEP_PERIODS=2); reference model tracks ramp position on a 30-step triangle.
// Honours LED_BREATH_GAMMA_EN for the expected duty.
module tb_led_breath_pwm;

   localparam int PB   = 4;
   localparam int SP   = 2;
   localparam int MAXV = (1 << PB) - 1;

   logic          clk = 1'b0;
   logic          rst, en, mode;
   logic          led;
   logic [PB-1:0] level;
   logic          period_tick;

   int vectors     = 0;
   int miscompares = 0;

   int m_cnt, m_sc, m_pos, m_lvl, m_duty, m_led, m_tick;
   int obs_ticks = 0, exp_ticks = 0;
   int obs_highs = 0, exp_highs = 0;

   led_breath_pwm #(.PWM_BITS(PB), .STEP_PERIODS(SP)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .mode        (mode),
      .led         (led),
      .level       (level),
      .period_tick (period_tick)
   );

   always #5 clk = ~clk;

   function automatic int tri_level(input int p);
      return (p <= MAXV) ? p : 2 * MAXV - p;
   endfunction

   function automatic int map_duty(input int l);
`ifdef LED_BREATH_GAMMA_EN
      return (l * l) / (1 << PB);
`else
      return l;
`endif
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit e, input bit m);
      if (r) begin
         m_cnt = 0; m_sc = 0; m_pos = 0; m_lvl = 0; m_duty = 0;
         m_led = 0; m_tick = 0;
      end else if (!e) begin
         m_led = 0; m_tick = 0;
      end else begin
         m_led  = (m_cnt < m_duty) ? 1 : 0;
         m_tick = 0;
         if (m_cnt == MAXV) begin
            m_sc = (m_sc + 1) % SP;
            if (m_sc == 0) begin
               if (m) begin
                  m_lvl = (m_lvl != 0) ? 0 : MAXV;
                  m_pos = m_lvl;
               end else begin
                  m_pos = (m_pos + 1) % (2 * MAXV);
                  m_lvl = tri_level(m_pos);
               end
               m_tick = (m_lvl == 0) ? 1 : 0;
            end
            m_duty = map_duty(m_lvl);
         end
         m_cnt = (m_cnt + 1) % (1 << PB);
      end
   endtask

   task automatic cyc(input bit r, input bit e, input bit m);
      rst = r; en = e; mode = m;
      @(posedge clk);
      model_step(r, e, m);
      @(negedge clk);
      chk("led", 16'(led), 16'(m_led));
      chk("level", 16'(level), 16'(m_lvl));
      chk("period_tick", 16'(period_tick), 16'(m_tick));
      obs_ticks += int'(period_tick);
      exp_ticks += m_tick;
      obs_highs += int'(led);
      exp_highs += m_led;
   endtask

   initial begin
      int guard;
      bit md;
      rst = 1'b1; en = 1'b1; mode = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 3; i++) cyc(1, 1, 0);
      // Two full breaths exercise the top turnaround, the 1->0 tick and the 0->1 restart.
      for (int i = 0; i < 2000; i++) cyc(0, 1, 0);
      chk("tick_count_breathe", 16'(obs_ticks), 16'(exp_ticks));
      chk("led_highs_breathe", 16'(obs_highs), 16'(exp_highs));

      guard = 0;
      while (m_lvl != 0 && guard < 2000) begin cyc(0, 1, 0); guard++; end
      chk("reach_level0", 16'(m_lvl), 16'd0);
      for (int i = 0; i < 200; i++) cyc(0, 1, 1);

      guard = 0;
      while (m_lvl != 7 && guard < 2000) begin cyc(0, 1, 0); guard++; end
      chk("reach_level7", 16'(m_lvl), 16'd7);
      for (int i = 0; i < 100; i++) cyc(0, 0, 0);
      for (int i = 0; i < 100; i++) cyc(0, 1, 0);

      guard = 0;
      while (!(m_lvl == 10 && m_pos > MAXV) && guard < 2000) begin cyc(0, 1, 0); guard++; end
      chk("reach_level10_down", 16'(m_lvl), 16'd10);
      cyc(1, 1, 1);
      for (int i = 0; i < 200; i++) cyc(0, 1, 0);

      // Mid-ramp switch to blink, then back.
      for (int i = 0; i < 150; i++) cyc(0, 1, 1);
      for (int i = 0; i < 150; i++) cyc(0, 1, 0);

      md = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) == 0) md = ~md;
         cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 9) != 0), md);
      end
      chk("tick_count_total", 16'(obs_ticks), 16'(exp_ticks));
      chk("led_highs_total", 16'(obs_highs), 16'(exp_highs));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
